ctrl_pipe_ext: RTL and testbench
================================

Name: ctrl_pipe_ext

Overview:
- Parametrised Execute/Memory/Writeback control pipeline for the 5-stage RISC-V core; successor to the fixed-width controller pipeline.
- Takes decoded Decode-stage control fields and carries them through the E, M and W registers. Adds per-stage valid bits, per-stage stall and flush, and full funct3 branch evaluation from ALU flags.
- Sits between the main/ALU decoders and the datapath/hazard unit.

Parameters:
- RS_W, 2, width of the ResultSrc field.
- ALUC_W, 3, width of the ALUControl field.
- CNT_W, 32, width of the retire counter (optional feature only).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ValidD  in  1  Decode holds a real instruction
- RegWriteD  in  1  decoded register-write enable
- ResultSrcD  in  RS_W  decoded writeback source select
- MemWriteD  in  1  decoded store enable
- JumpD  in  1  decoded jump
- BranchD  in  1  decoded branch
- funct3D  in  3  branch type
- ALUControlD  in  ALUC_W  decoded ALU operation
- ALUSrcAD  in  1  decoded ALU operand-A select
- ALUSrcBD  in  1  decoded ALU operand-B select
- StallE  in  1  hold the E register
- StallM  in  1  hold the M register
- FlushE  in  1  bubble the E register
- FlushM  in  1  bubble the M register
- ZeroE  in  1  ALU flag Z (A-B)
- NegE  in  1  ALU flag N
- OvfE  in  1  ALU flag V
- CarryE  in  1  ALU carry out of A+~B+1
- PCSrcE  out  1  redirect fetch
- BranchErrE  out  1  illegal branch funct3 in E
- ALUControlE  out  ALUC_W  ALU operation for E
- ALUSrcAE  out  1  ALU operand-A select for E
- ALUSrcBE  out  1  ALU operand-B select for E
- ResultSrcE  out  RS_W  writeback source in E
- LoadE  out  1  valid load in E (ResultSrcE==1), for the hazard unit
- MemWriteM  out  1  store enable in M
- RegWriteM  out  1  register-write enable in M
- RegWriteW  out  1  register-write enable in W
- ResultSrcW  out  RS_W  writeback source in W
- ValidW  out  1  W holds a real instruction
- retired_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset: all stage registers, including valid bits, clear to 0, so every output is 0 in the cycle after reset is sampled high.
- Reset mid-operation discards all in-flight control.
- Effective stalls: StallE_eff = StallE | StallM. A stalled M forces E to hold; StallM=1 with StallE=0 is illegal and is guarded by a simulation assertion.
- E register, priority reset > FlushE > StallE_eff > load:
  - flush: all fields 0, ValidE=0.
  - stall: hold.
  - load: all D fields, ValidE=ValidD.
- M register, priority reset > FlushM > StallM > load:
  - If StallE_eff=1 and StallM=0, M loads a bubble (all 0).
  - Otherwise it loads from E.
- W register: no stall or flush.
  - If StallM=1, W loads a bubble.
  - Otherwise it loads from M every cycle.
- Latency: a D field appears at E one cycle after load, at M after two cycles, at W after three cycles (no stalls).
- Valid gating:
  - RegWriteM, MemWriteM and RegWriteW are each ANDed with their stage valid bit.
  - LoadE = ValidE & (ResultSrcE==1).
- Branch condition, selected by funct3E:
  - 000 Z; 001 ~Z; 100 N^V; 101 ~(N^V); 110 ~C; 111 C.
  - 010 and 011 give cond=0, and BranchErrE = ValidE & BranchE for that case.
- PCSrcE = ValidE & ~StallE_eff & (JumpE | (BranchE & cond)). Combinational; asserted exactly once per instruction, in the cycle it leaves E.
- Simultaneous FlushE and StallE: flush wins.

Optional Feature:
- Macro: CTRL_PIPE_RETIRE_CNT_EN.
- Defined: retired_cnt is a CNT_W-bit register. It resets to 0, increments by 1 in every cycle with ValidW=1, and wraps from all-ones to 0.
- Undefined: retired_cnt is tied to 0 and no counter register exists.

Test Plan:
- Reset, then ValidD=1, RegWriteD=1, ResultSrcD=2 for 1 cycle -> RegWriteW=1, ResultSrcW=2, ValidW=1 exactly 3 cycles later; all outputs 0 before that.
- Branch funct3=100 with N=1, V=0 -> PCSrcE=1. Same with N=1, V=1 -> PCSrcE=0. funct3=110 with C=0 -> PCSrcE=1.
- BranchD=1, funct3D=010 -> BranchErrE=1, PCSrcE=0.
- Jump in E with StallE=1 for 2 cycles -> PCSrcE=0 during the stall, 1 in the release cycle; M receives bubbles while E is stalled (MemWriteM=0, RegWriteM=0).
- FlushE=1 and StallE=1 together on a store -> E becomes a bubble; MemWriteM stays 0; FlushM on a valid M -> RegWriteW=0 next cycle.
- With CTRL_PIPE_RETIRE_CNT_EN and CNT_W=4: 17 valid instructions -> retired_cnt = 1 (wrapped). Without the macro -> retired_cnt = 0 throughout.

Source files
------------

// File: rtl/ctrl_pipe_ext.sv
// =============================================================================
// Module   : ctrl_pipe_ext
// Purpose  : E/M/W control pipeline with valid bits, stall/flush and funct3
//            branch evaluation; optional retire counter via CTRL_PIPE_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module ctrl_pipe_ext #(
    parameter int RS_W   = 2,
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic [RS_W-1:0]   ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic [2:0]        funct3D,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic              ALUSrcAD,
    input  logic              ALUSrcBD,
    input  logic              StallE,
    input  logic              StallM,
    input  logic              FlushE,
    input  logic              FlushM,
    input  logic              ZeroE,
    input  logic              NegE,
    input  logic              OvfE,
    input  logic              CarryE,
    output logic              PCSrcE,
    output logic              BranchErrE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              ALUSrcAE,
    output logic              ALUSrcBE,
    output logic [RS_W-1:0]   ResultSrcE,
    output logic              LoadE,
    output logic              MemWriteM,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic [RS_W-1:0]   ResultSrcW,
    output logic              ValidW,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [RS_W-1:0] c_resultSrcLoad = RS_W'(1);

    logic              w_stallEEff;
    logic              w_cond;
    logic              w_badFunct3;

    logic              r_validE, r_regWriteE, r_memWriteE, r_jumpE, r_branchE;
    logic              r_aluSrcAE, r_aluSrcBE;
    logic [RS_W-1:0]   r_resultSrcE;
    logic [2:0]        r_funct3E;
    logic [ALUC_W-1:0] r_aluControlE;

    logic              r_validM, r_regWriteM, r_memWriteM;
    logic [RS_W-1:0]   r_resultSrcM;

    logic              r_validW, r_regWriteW;
    logic [RS_W-1:0]   r_resultSrcW;

    // A stalled M cannot accept E's instruction, so E must hold too.
    assign w_stallEEff = StallE | StallM;

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_validE      <= 1'b0;
            r_regWriteE   <= 1'b0;
            r_resultSrcE  <= '0;
            r_memWriteE   <= 1'b0;
            r_jumpE       <= 1'b0;
            r_branchE     <= 1'b0;
            r_funct3E     <= '0;
            r_aluControlE <= '0;
            r_aluSrcAE    <= 1'b0;
            r_aluSrcBE    <= 1'b0;
        end else if (!w_stallEEff) begin
            r_validE      <= ValidD;
            r_regWriteE   <= RegWriteD;
            r_resultSrcE  <= ResultSrcD;
            r_memWriteE   <= MemWriteD;
            r_jumpE       <= JumpD;
            r_branchE     <= BranchD;
            r_funct3E     <= funct3D;
            r_aluControlE <= ALUControlD;
            r_aluSrcAE    <= ALUSrcAD;
            r_aluSrcBE    <= ALUSrcBD;
        end
    end

    // E held while M free: M takes a bubble rather than a duplicate of E.
    always_ff @(posedge clk) begin
        if (reset || FlushM || (w_stallEEff && !StallM)) begin
            r_validM     <= 1'b0;
            r_regWriteM  <= 1'b0;
            r_memWriteM  <= 1'b0;
            r_resultSrcM <= '0;
        end else if (!StallM) begin
            r_validM     <= r_validE;
            r_regWriteM  <= r_regWriteE;
            r_memWriteM  <= r_memWriteE;
            r_resultSrcM <= r_resultSrcE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || StallM) begin
            r_validW     <= 1'b0;
            r_regWriteW  <= 1'b0;
            r_resultSrcW <= '0;
        end else begin
            r_validW     <= r_validM;
            r_regWriteW  <= r_regWriteM;
            r_resultSrcW <= r_resultSrcM;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(StallM && !StallE));
        end
    end

    always_comb begin
        w_cond      = 1'b0;
        w_badFunct3 = 1'b0;
        case (r_funct3E)
            3'b000:  w_cond = ZeroE;
            3'b001:  w_cond = ~ZeroE;
            3'b100:  w_cond = NegE ^ OvfE;
            3'b101:  w_cond = ~(NegE ^ OvfE);
            3'b110:  w_cond = ~CarryE;
            3'b111:  w_cond = CarryE;
            default: w_badFunct3 = 1'b1;
        endcase
    end

    assign PCSrcE      = r_validE & ~w_stallEEff & (r_jumpE | (r_branchE & w_cond));
    assign BranchErrE  = r_validE & r_branchE & w_badFunct3;
    assign ALUControlE = r_aluControlE;
    assign ALUSrcAE    = r_aluSrcAE;
    assign ALUSrcBE    = r_aluSrcBE;
    assign ResultSrcE  = r_resultSrcE;
    assign LoadE       = r_validE & (r_resultSrcE == c_resultSrcLoad);
    assign MemWriteM   = r_memWriteM & r_validM;
    assign RegWriteM   = r_regWriteM & r_validM;
    assign RegWriteW   = r_regWriteW & r_validW;
    assign ResultSrcW  = r_resultSrcW;
    assign ValidW      = r_validW;

`ifdef CTRL_PIPE_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retiredCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retiredCnt <= '0;
        end else if (r_validW) begin
            r_retiredCnt <= r_retiredCnt + CNT_W'(1);
        end
    end

    assign retired_cnt = r_retiredCnt;
`else
    assign retired_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_ext.sv
// =============================================================================
// Module   : tb_ctrl_pipe_ext
// Purpose  : Directed self-checking bench for ctrl_pipe_ext (CNT_W = 4).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_ctrl_pipe_ext;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcAD, ALUSrcBD;
    logic [1:0] ResultSrcD;
    logic [2:0] funct3D, ALUControlD;
    logic       StallE, StallM, FlushE, FlushM, ZeroE, NegE, OvfE, CarryE;
    logic       PCSrcE, BranchErrE, ALUSrcAE, ALUSrcBE, LoadE;
    logic       MemWriteM, RegWriteM, RegWriteW, ValidW;
    logic [2:0] ALUControlE;
    logic [1:0] ResultSrcE, ResultSrcW;
    logic [3:0] retired_cnt;

    int checks = 0;
    int errors = 0;

    ctrl_pipe_ext #(.RS_W(2), .ALUC_W(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .funct3D(funct3D), .ALUControlD(ALUControlD),
        .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .StallE(StallE),
        .StallM(StallM), .FlushE(FlushE), .FlushM(FlushM), .ZeroE(ZeroE),
        .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE), .PCSrcE(PCSrcE),
        .BranchErrE(BranchErrE), .ALUControlE(ALUControlE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
        .LoadE(LoadE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ValidW(ValidW),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearD();
        ValidD = 0; RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0;
        BranchD = 0; funct3D = 0; ALUControlD = 0; ALUSrcAD = 0; ALUSrcBD = 0;
    endtask

    task automatic loadBranch(input logic [2:0] f3);
        clearD();
        ValidD = 1; BranchD = 1; funct3D = f3;
        tick();
        clearD();
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_outs"}, {PCSrcE, BranchErrE, ALUControlE, ALUSrcAE, ALUSrcBE,
                             ResultSrcE, LoadE, MemWriteM, RegWriteM, RegWriteW,
                             ResultSrcW, ValidW}, 32'h0);
        chk({tag, "_cnt"}, retired_cnt, 32'h0);
    endtask

    initial begin
        clearD();
        StallE = 0; StallM = 0; FlushE = 0; FlushM = 0;
        ZeroE = 0; NegE = 0; OvfE = 0; CarryE = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        chkAllZero("reset");

        // Basic latency: ALU-result writeback appears in W three edges later.
        ValidD = 1; RegWriteD = 1; ResultSrcD = 2;
        tick();
        clearD();
        chk("lat1_resE", ResultSrcE, 2);
        chk("lat1_loadE", LoadE, 0);
        chk("lat1_validW", ValidW, 0);
        chk("lat1_regWM", RegWriteM, 0);
        tick();
        chk("lat2_regWM", RegWriteM, 1);
        chk("lat2_regWW", RegWriteW, 0);
        chk("lat2_validW", ValidW, 0);
        tick();
        chk("lat3_regWW", RegWriteW, 1);
        chk("lat3_resW", ResultSrcW, 2);
        chk("lat3_validW", ValidW, 1);
        tick();
        chk("lat4_validW", ValidW, 0);

        // Load detection for the hazard unit.
        ValidD = 1; ResultSrcD = 1;
        tick();
        clearD();
        chk("loadE_valid", LoadE, 1);
        ResultSrcD = 1;
        tick();
        clearD();
        chk("loadE_invalid", LoadE, 0);

        // Branch condition evaluation.
        loadBranch(3'b100);
        NegE = 1; OvfE = 0; settle();
        chk("blt_n1v0", PCSrcE, 1);
        OvfE = 1; settle();
        chk("blt_n1v1", PCSrcE, 0);
        chk("blt_err", BranchErrE, 0);
        NegE = 0; OvfE = 0;
        loadBranch(3'b110);
        CarryE = 0; settle();
        chk("bltu_c0", PCSrcE, 1);
        CarryE = 1; settle();
        chk("bltu_c1", PCSrcE, 0);
        loadBranch(3'b000);
        ZeroE = 1; settle();
        chk("beq_z1", PCSrcE, 1);
        loadBranch(3'b001);
        settle();
        chk("bne_z1", PCSrcE, 0);
        ZeroE = 0; settle();
        chk("bne_z0", PCSrcE, 1);
        BranchD = 1; funct3D = 3'b001;
        tick();
        clearD();
        chk("bne_invalid", PCSrcE, 0);
        loadBranch(3'b010);
        ZeroE = 1; NegE = 1; CarryE = 1; settle();
        chk("bad_f3_err", BranchErrE, 1);
        chk("bad_f3_pc", PCSrcE, 0);
        ZeroE = 0; NegE = 0; CarryE = 0;

        // Jump held in E by StallE for two cycles.
        ValidD = 1; JumpD = 1; RegWriteD = 1;
        tick();
        clearD();
        StallE = 1; settle();
        chk("jmp_stall1_pc", PCSrcE, 1'b0);
        tick();
        chk("jmp_stall2_pc", PCSrcE, 0);
        chk("jmp_stall2_regWM", RegWriteM, 0);
        chk("jmp_stall2_memWM", MemWriteM, 0);
        tick();
        StallE = 0; settle();
        chk("jmp_rel_pc", PCSrcE, 1);
        chk("jmp_rel_regWM", RegWriteM, 0);
        tick();
        chk("jmp_post_pc", PCSrcE, 0);
        chk("jmp_post_regWM", RegWriteM, 1);

        // FlushE beats StallE on a store.
        ValidD = 1; MemWriteD = 1; ALUSrcBD = 1; ALUControlD = 3'b101;
        tick();
        clearD();
        chk("st_aluE", ALUControlE, 3'b101);
        FlushE = 1; StallE = 1;
        tick();
        FlushE = 0; StallE = 0;
        chk("st_flush_aluE", ALUControlE, 0);
        chk("st_flush_srcBE", ALUSrcBE, 0);
        chk("st_flush_memWM", MemWriteM, 0);
        tick();
        chk("st_after_memWM", MemWriteM, 0);

        // FlushM as the instruction moves E->M.
        ValidD = 1; RegWriteD = 1;
        tick();
        clearD();
        FlushM = 1;
        tick();
        FlushM = 0;
        chk("flm_regWM", RegWriteM, 0);
        tick();
        chk("flm_regWW", RegWriteW, 0);
        chk("flm_validW", ValidW, 0);

        // StallM holds M and sends a bubble to W.
        ValidD = 1; RegWriteD = 1;
        tick();
        clearD();
        tick();
        chk("stm_regWM", RegWriteM, 1);
        StallE = 1; StallM = 1;
        tick();
        chk("stm_hold_regWM", RegWriteM, 1);
        chk("stm_hold_regWW", RegWriteW, 0);
        StallE = 0; StallM = 0;
        tick();
        chk("stm_rel_regWW", RegWriteW, 1);

        // Reset mid-flight discards everything.
        ValidD = 1; RegWriteD = 1; MemWriteD = 1; JumpD = 1; ResultSrcD = 1;
        tick();
        tick();
        clearD();
        reset = 1;
        tick();
        reset = 0;
        chkAllZero("midreset");

        // 17 consecutive retirements.
        ValidD = 1;
        for (int i = 0; i < 17; i++) tick();
        clearD();
        tick(); tick(); tick(); tick();
`ifdef CTRL_PIPE_RETIRE_CNT_EN
        chk("retire_wrap", retired_cnt, 1);
`else
        chk("retire_off", retired_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
